// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the ctrl decoder.
// Latency: none (constants, types and pure decode helpers only).
// Backpressure: none; the busy/stall contract lives in mdu.
package mdu_pkg;

  // Operation encodings carried on mdOp; codes 9..15 behave as MDU_NONE.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  // Default busy-window lengths for the arithmetic operations.
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Codes that open a busy window (MULT, MULTU, DIV, DIVU).
  function automatic logic mdu_is_arith(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Codes that are accepted as a request (arithmetic plus MTHI/MTLO).
  function automatic logic mdu_is_accept(input logic [3:0] op);
    return mdu_is_arith(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

  // Codes that stall on busy in the hazard unit (everything 1..8).
  function automatic logic mdu_is_stallable(input logic [3:0] op);
    return mdu_is_accept(op) || (op == MDU_MFHI) || (op == MDU_MFLO);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit holding architectural HI/LO; MULT/DIV results commit after a fixed window.
// Latency: MULT*/DIV* visible MULT_CYCLES/DIV_CYCLES cycles after acceptance; MTHI/MTLO next cycle; MFHI/MFLO combinational.
// Backpressure: busy is high for the whole window; requests arriving while busy are dropped, so the hazard unit must stall them.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdEn,
  input  logic [3:0]  mdOp,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        busy,
  output logic [31:0] mdRes
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Architectural and pending state.
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      p_hi;
  logic [31:0]      p_lo;
  logic             commit;

  // Request qualification.
  logic accept;
  logic accept_arith;

  // Combinational arithmetic on the acceptance-cycle operands.
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] mul_s;
  logic        [63:0] mul_u;
  logic               div_zero;
  logic               div_ovf;
  logic        [31:0] divisor_u;
  logic signed [31:0] dividend_s;
  logic signed [31:0] divisor_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  // Values captured into the pending registers on acceptance.
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_commit;
  logic [CNT_W-1:0] res_load;

  assign busy         = (cnt != '0);
  assign accept       = mdEn && !busy && mdu_is_accept(mdOp);
  assign accept_arith = accept && mdu_is_arith(mdOp);

  // Products: sign-extend for MULT, zero-extend for MULTU; the low 64 bits are exact.
  assign a_sx  = {{32{inA[31]}}, inA};
  assign b_sx  = {{32{inB[31]}}, inB};
  assign mul_s = a_sx * b_sx;
  assign mul_u = {32'd0, inA} * {32'd0, inB};

  // Divisor is forced to 1 for /0 and for the one signed overflow case so the
  // divider never sees an undefined operand pair; those cases are patched below.
  assign div_zero   = (inB == 32'd0);
  assign div_ovf    = (inA == 32'h8000_0000) && (inB == 32'hFFFF_FFFF);
  assign divisor_u  = div_zero ? 32'd1 : inB;
  assign dividend_s = inA;
  assign divisor_s  = (div_zero || div_ovf) ? 32'sd1 : inB;

  // Signed divide truncates toward zero; remainder follows the dividend's sign.
  assign quo_s = div_ovf ? 32'sh8000_0000 : (dividend_s / divisor_s);
  assign rem_s = div_ovf ? 32'sd0         : (dividend_s % divisor_s);
  assign quo_u = inA / divisor_u;
  assign rem_u = inA % divisor_u;

  // Select the pending result, commit flag and window length for the requested op.
  always_comb begin
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_commit = 1'b0;
    res_load   = '0;
    case (mdOp)
      MDU_MULT: begin
        res_hi     = mul_s[63:32];
        res_lo     = mul_s[31:0];
        res_commit = 1'b1;
        res_load   = MULT_LOAD;
      end
      MDU_MULTU: begin
        res_hi     = mul_u[63:32];
        res_lo     = mul_u[31:0];
        res_commit = 1'b1;
        res_load   = MULT_LOAD;
      end
      MDU_DIV: begin
        res_hi     = rem_s;
        res_lo     = quo_s;
        res_commit = !div_zero;
        res_load   = DIV_LOAD;
      end
      MDU_DIVU: begin
        res_hi     = rem_u;
        res_lo     = quo_u;
        res_commit = !div_zero;
        res_load   = DIV_LOAD;
      end
      default: begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_commit = 1'b0;
        res_load   = '0;
      end
    endcase
  end

  // Counter, pending result, HI/LO writes and end-of-window commit; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      commit <= 1'b0;
    end else if (accept_arith) begin
      cnt    <= res_load;
      p_hi   <= res_hi;
      p_lo   <= res_lo;
      commit <= res_commit;
    end else if (accept) begin
      // Only MTHI/MTLO reach here; they never open a busy window.
      if (mdOp == MDU_MTHI) hi <= inA;
      if (mdOp == MDU_MTLO) lo <= inA;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if ((cnt == CNT_ONE) && commit) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end
  end

  // Read port: independent of mdEn and busy, so it shows committed HI/LO only.
  always_comb begin
    mdRes = 32'd0;
    case (mdOp)
      MDU_MFHI: mdRes = hi;
      MDU_MFLO: mdRes = lo;
      default:  mdRes = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops against a plain-arithmetic model.
// Latency: checks busy-window lengths of 5 (MULT*) and 10 (DIV*) and next-cycle MTHI/MTLO visibility.
// Backpressure: checks that requests during busy are dropped and reset aborts a pending commit.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdEn;
  logic [3:0]  mdOp;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        busy;
  logic [31:0] mdRes;

  int total = 0;
  int bad   = 0;

  // Reference architectural state.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdEn  (mdEn),
    .mdOp  (mdOp),
    .inA   (inA),
    .inB   (inB),
    .busy  (busy),
    .mdRes (mdRes)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural effect of one accepted op, from plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      OP_DIV: if (b != 32'd0) begin
        sq = longint'(signed'(a)) / longint'(signed'(b));
        sr = longint'(signed'(a)) % longint'(signed'(b));
        lo = sq[31:0];
        hi = sr[31:0];
      end
      OP_DIVU: if (b != 32'd0) begin
        lo = a / b;
        hi = a % b;
      end
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == OP_MULT || op == OP_MULTU) return 5;
    if (op == OP_DIV || op == OP_DIVU) return 10;
    return 0;
  endfunction

  // Read HI and LO through the combinational port (mdEn irrelevant); stays inside one low phase.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    logic [3:0] save;
    save = mdOp;
    mdOp = OP_MFHI;
    #1 hi = mdRes;
    mdOp = OP_MFLO;
    #1 lo = mdRes;
    mdOp = save;
  endtask

  // Present a request for one cycle; called mid-cycle, returns at the next negedge with operands scrambled.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdEn = 1'b1;
    mdOp = op;
    inA  = a;
    inB  = b;
    @(negedge clk);
    mdEn = 1'b0;
    mdOp = OP_NONE;
    inA  = $urandom;
    inB  = $urandom;
  endtask

  // Issue an op, sample HI/LO in the first cycle after acceptance, then count busy cycles (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    issue(op, a, b);
    read_hilo(mid_hi, mid_lo);
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 40) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1;
    mdEn  = 1'b0;
    mdOp  = OP_NONE;
    inA   = 32'd0;
    inB   = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (mdRes !== 32'd0) begin bad++; $display("FAIL reset_mdres_none: got %h expected 0", mdRes); end
    mdOp = OP_DIV;
    #1;
    total++;
    if (mdRes !== 32'd0) begin bad++; $display("FAIL mdres_nonread_op: got %h expected 0", mdRes); end
    mdOp = OP_NONE;
    read_hilo(h, l);
    total++;
    if (h !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h expected 0", h); end
    total++;
    if (l !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h expected 0", l); end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    int n;
    logic [31:0] mh, ml, h, l;
    do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (n != 5) begin bad++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
    total++;
    if (mh !== 32'd0 || ml !== 32'd0) begin bad++; $display("FAIL mult_mid_read: got %h/%h expected 0/0", mh, ml); end
    total++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mult_result: got %h/%h expected ffffffff/fffffffe", h, l);
    end
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_multu();
    int n;
    logic [31:0] mh, ml, h, l;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (n != 5) begin bad++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
    total++;
    if (mh !== m_hi || ml !== m_lo) begin bad++; $display("FAIL multu_mid_read: got %h/%h expected %h/%h", mh, ml, m_hi, m_lo); end
    total++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL multu_result: got %h/%h expected 00000001/fffffffe", h, l);
    end
    m_hi = 32'h0000_0001;
    m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div();
    int n;
    logic [31:0] mh, ml, h, l;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (n != 10) begin bad++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
    total++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div_neg_result: got %h/%h expected ffffffff/fffffffd", h, l);
    end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'h8000_0000) begin
      bad++; $display("FAIL div_overflow_result: got %h/%h expected 00000000/80000000", h, l);
    end
    m_hi = 32'd0;
    m_lo = 32'h8000_0000;
  endtask

  task automatic test_divu_zero();
    int n;
    logic [31:0] mh, ml, h, l;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    read_hilo(h, l);
    total++;
    if (h !== 32'h1234_5678) begin bad++; $display("FAIL mthi_value: got %h expected 12345678", h); end
    issue(OP_MTLO, 32'hCAFE_BABE, 32'd0);
    read_hilo(h, l);
    total++;
    if (l !== 32'hCAFE_BABE || h !== 32'h1234_5678) begin
      bad++; $display("FAIL mtlo_value: got %h/%h expected 12345678/cafebabe", h, l);
    end
    do_op(OP_DIVU, 32'd7, 32'd0, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (n != 10) begin bad++; $display("FAIL divu_zero_busy_cycles: got %0d expected 10", n); end
    total++;
    if (h !== 32'h1234_5678 || l !== 32'hCAFE_BABE) begin
      bad++; $display("FAIL divu_zero_keeps_hilo: got %h/%h expected 12345678/cafebabe", h, l);
    end
    m_hi = 32'h1234_5678;
    m_lo = 32'hCAFE_BABE;
  endtask

  task automatic test_abort();
    logic [31:0] h, l;
    issue(OP_DIVU, 32'd100, 32'd7);     // now in busy cycle 1
    @(negedge clk);                     // busy cycle 2
    @(negedge clk);                     // busy cycle 3
    @(negedge clk);                     // busy cycle 4
    issue(OP_MTLO, 32'd1, 32'd0);       // dropped; now in busy cycle 5
    read_hilo(h, l);
    total++;
    if (busy !== 1'b1 || l !== m_lo) begin
      bad++; $display("FAIL mtlo_while_busy: got busy=%b lo=%h expected busy=1 lo=%h", busy, l, m_lo);
    end
    @(negedge clk);                     // busy cycle 6
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_hilo(h, l);
    total++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      bad++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h expected 0/0/0", busy, h, l);
    end
    repeat (12) @(negedge clk);
    read_hilo(h, l);
    total++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      bad++; $display("FAIL abort_no_late_commit: got busy=%b hi=%h lo=%h expected 0/0/0", busy, h, l);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] mh, ml, h, l;
    logic [31:0] eh, el;
    eh = m_hi;
    el = m_lo;
    model(OP_MULT, 32'd3, 32'hFFFF_FFFC, eh, el);
    do_op(OP_MULT, 32'd3, 32'hFFFF_FFFC, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (h !== eh || l !== el) begin bad++; $display("FAIL b2b_first: got %h/%h expected %h/%h", h, l, eh, el); end
    m_hi = eh;
    m_lo = el;
    // Issued in the first idle cycle after the window.
    model(OP_DIVU, 32'd100, 32'd7, eh, el);
    do_op(OP_DIVU, 32'd100, 32'd7, n, mh, ml);
    read_hilo(h, l);
    total++;
    if (n != 10) begin bad++; $display("FAIL b2b_second_cycles: got %0d expected 10", n); end
    total++;
    if (h !== 32'd2 || l !== 32'd14 || h !== eh || l !== el) begin
      bad++; $display("FAIL b2b_second: got %h/%h expected %h/%h", h, l, eh, el);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic test_random();
    int n;
    logic [3:0]  op;
    logic [31:0] a, b, mh, ml, h, l, eh, el;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (op == OP_MFHI || op == OP_MFLO) begin
        mdEn = 1'($urandom_range(0, 1));
        mdOp = op;
        inA  = a;
        inB  = b;
        #1;
        total++;
        if (mdRes !== ((op == OP_MFHI) ? m_hi : m_lo)) begin
          bad++; $display("FAIL rand_read[%0d] op=%0d: got %h expected %h", i, op, mdRes, (op == OP_MFHI) ? m_hi : m_lo);
        end
        @(negedge clk);
        mdEn = 1'b0;
        mdOp = OP_NONE;
      end else begin
        eh = m_hi;
        el = m_lo;
        model(op, a, b, eh, el);
        do_op(op, a, b, n, mh, ml);
        read_hilo(h, l);
        total++;
        if (n != exp_cycles(op)) begin
          bad++; $display("FAIL rand_cycles[%0d] op=%0d: got %0d expected %0d", i, op, n, exp_cycles(op));
        end
        if (exp_cycles(op) != 0) begin
          total++;
          if (mh !== m_hi || ml !== m_lo) begin
            bad++; $display("FAIL rand_mid[%0d] op=%0d: got %h/%h expected %h/%h", i, op, mh, ml, m_hi, m_lo);
          end
        end
        total++;
        if (h !== eh || l !== el) begin
          bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h/%h expected %h/%h", i, op, a, b, h, l, eh, el);
        end
        m_hi = eh;
        m_lo = el;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
